// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO controllers: pointer width rule and
// Gray/binary conversion on a 32-bit carrier (callers cast to their own width).
package fifo_pkg;

   localparam int unsigned FUNC_W = 32;

   // Pointers carry one wrap bit above the address.
   function automatic int unsigned ptr_w(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

   function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] v);
      return v ^ (v >> 1);
   endfunction

   // Zero-extended upper bits leave the prefix XOR unaffected.
   function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] v);
      logic [FUNC_W-1:0] b;
      b[FUNC_W-1] = v[FUNC_W-1];
      for (int i = int'(FUNC_W) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ v[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-domain bundle between the FIFO read controller and its environment.
interface fifo_rd_ctrl_if
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 3
);
   localparam int unsigned PTR_W = ptr_w(ADDR_WIDTH);

   logic                  rinc;
   logic [PTR_W-1:0]      rq2_wptr;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [PTR_W-1:0]      rptr_gray;
   logic                  rempty;
   logic                  ralmost_empty;
   logic [PTR_W-1:0]      rlevel;
   logic                  runderflow;

   // Consumer / synchroniser side.
   modport master (
      output rinc, rq2_wptr,
      input  raddr, rptr_gray, rempty, ralmost_empty, rlevel, runderflow
   );

   // Controller side.
   modport slave (
      input  rinc, rq2_wptr,
      output raddr, rptr_gray, rempty, ralmost_empty, rlevel, runderflow
   );

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down);
// shared by the read and write controllers.
module fifo_gray2bin #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   for (genvar i = 0; i < int'(W); i++) begin : g_bit
      assign bin_o[i] = ^gray_i[W-1:i];
   end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: binary read counter, registered
// Gray pointer for the write domain, and registered empty/level/underflow flags.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AE_LEVEL   = 1
) (
   input  logic          rclk,
   input  logic          rrst_n,
   fifo_rd_ctrl_if.slave rd
);

   localparam int unsigned PTR_W = ptr_w(ADDR_WIDTH);

   logic [PTR_W-1:0] rbin_q,  rbin_d;
   logic [PTR_W-1:0] rgray_q, rgray_d;
   logic [PTR_W-1:0] rlevel_q, rlevel_d;
   logic             rempty_q, rempty_d;
   logic             rae_q, rae_d;
   logic             runderflow_q, runderflow_d;
   logic             rd_en_c;
   logic [PTR_W-1:0] wbin_c;

   fifo_gray2bin #(.W(PTR_W)) u_wptr_g2b (
      .gray_i (rd.rq2_wptr),
      .bin_o  (wbin_c)
   );

   // Next-state: flags are computed from the post-read pointer so a read of
   // the last word raises empty at the same edge that advances the pointer.
   always_comb begin
      rd_en_c      = rd.rinc & ~rempty_q;
      rbin_d       = rbin_q + PTR_W'(rd_en_c);
      rgray_d      = PTR_W'(bin2gray(FUNC_W'(rbin_d)));
      rlevel_d     = wbin_c - rbin_d;
      rempty_d     = (rgray_d == rd.rq2_wptr);
      rae_d        = (rlevel_d <= PTR_W'(AE_LEVEL));
      runderflow_d = rd.rinc & rempty_q;
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin_q       <= '0;
         rgray_q      <= '0;
         rlevel_q     <= '0;
         rempty_q     <= 1'b1;
         rae_q        <= 1'b1;
         runderflow_q <= 1'b0;
      end else begin
         rbin_q       <= rbin_d;
         rgray_q      <= rgray_d;
         rlevel_q     <= rlevel_d;
         rempty_q     <= rempty_d;
         rae_q        <= rae_d;
         runderflow_q <= runderflow_d;
      end
   end

   // rptr_gray leaves the domain straight from its flop.
   assign rd.raddr         = rbin_q[ADDR_WIDTH-1:0];
   assign rd.rptr_gray     = rgray_q;
   assign rd.rlevel        = rlevel_q;
   assign rd.rempty        = rempty_q;
   assign rd.ralmost_empty = rae_q;
   assign rd.runderflow    = runderflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (ADDR_WIDTH=3, AE_LEVEL=1).
module tb_fifo_rd_ctrl;

   localparam int unsigned AW = 3;

   logic rclk = 1'b0;
   logic rrst_n;

   always #5 rclk = ~rclk;

   fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) rif ();

   fifo_rd_ctrl #(.ADDR_WIDTH(AW), .AE_LEVEL(1)) dut (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .rd     (rif.slave)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: words written / read as plain unbounded counts.
   int rd_cnt = 0;
   int wr_cnt = 0;
   int m_level = 0;
   bit m_uf = 1'b0;

   typedef struct {
      string      name;
      bit         rinc;
      logic [3:0] wptr;
      int         level;
      bit         empty;
      bit         ae;
      bit         uf;
      int         raddr;
      logic [3:0] gray;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [3:0] g4(input int v);
      logic [3:0] b;
      b = 4'(v);
      return b ^ (b >> 1);
   endfunction

   task automatic addv(input string n, input bit ri, input logic [3:0] w, input int l,
                       input bit e, input bit a, input bit u, input int ra, input logic [3:0] g);
      vec_t v;
      v.name = n; v.rinc = ri; v.wptr = w; v.level = l; v.empty = e;
      v.ae = a; v.uf = u; v.raddr = ra; v.gray = g;
      vq.push_back(v);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " raddr"},  int'(rif.raddr), 0);
      chk({tag, " gray"},   int'(rif.rptr_gray), 0);
      chk({tag, " empty"},  int'(rif.rempty), 1);
      chk({tag, " ae"},     int'(rif.ralmost_empty), 1);
      chk({tag, " level"},  int'(rif.rlevel), 0);
      chk({tag, " uflow"},  int'(rif.runderflow), 0);
   endtask

   task automatic reset_dut();
      rrst_n = 1'b0;
      rif.rinc = 1'b0;
      rif.rq2_wptr = '0;
      repeat (2) @(negedge rclk);
      chk_reset_vals("reset");
      rrst_n = 1'b1;
      rd_cnt = 0; wr_cnt = 0; m_level = 0; m_uf = 1'b0;
   endtask

   // Drive at the falling edge, let one rising edge happen, update the model.
   task automatic step(input bit ri, input int wcnt);
      bit accept;
      rif.rinc = ri;
      wr_cnt = wcnt;
      rif.rq2_wptr = g4(wcnt);
      @(posedge rclk);
      accept = ri && (m_level != 0);
      m_uf = ri && (m_level == 0);
      if (accept) rd_cnt++;
      m_level = wr_cnt - rd_cnt;
      @(negedge rclk);
   endtask

   task automatic check_model(input string tag);
      chk({tag, " raddr"}, int'(rif.raddr), rd_cnt % 8);
      chk({tag, " gray"},  int'(rif.rptr_gray), int'(g4(rd_cnt)));
      chk({tag, " empty"}, int'(rif.rempty), int'(m_level == 0));
      chk({tag, " ae"},    int'(rif.ralmost_empty), int'(m_level <= 1));
      chk({tag, " level"}, int'(rif.rlevel), m_level);
      chk({tag, " uflow"}, int'(rif.runderflow), int'(m_uf));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rrst_n = 1'b1;
      rif.rinc = 1'b0;
      rif.rq2_wptr = '0;
      @(negedge rclk);

      // Directed table: fill to 5, drain, underflow, concurrent read+write.
      addv("load5", 1'b0, 4'b0111, 5, 0, 0, 0, 0, 4'b0000);
      addv("rd1",   1'b1, 4'b0111, 4, 0, 0, 0, 1, 4'b0001);
      addv("rd2",   1'b1, 4'b0111, 3, 0, 0, 0, 2, 4'b0011);
      addv("rd3",   1'b1, 4'b0111, 2, 0, 0, 0, 3, 4'b0010);
      addv("rd4",   1'b1, 4'b0111, 1, 0, 1, 0, 4, 4'b0110);
      addv("rd5",   1'b1, 4'b0111, 0, 1, 1, 0, 5, 4'b0111);
      addv("uflow", 1'b1, 4'b0111, 0, 1, 1, 1, 5, 4'b0111);
      addv("idle",  1'b0, 4'b0111, 0, 1, 1, 0, 5, 4'b0111);
      addv("wr8",   1'b0, 4'b1100, 3, 0, 0, 0, 5, 4'b0111);
      addv("rdwr",  1'b1, 4'b1101, 3, 0, 0, 0, 6, 4'b0101);
      addv("rd7",   1'b1, 4'b1101, 2, 0, 0, 0, 7, 4'b0100);

      reset_dut();
      foreach (vq[i]) begin
         rif.rinc = vq[i].rinc;
         rif.rq2_wptr = vq[i].wptr;
         @(posedge rclk);
         @(negedge rclk);
         chk({vq[i].name, " level"}, int'(rif.rlevel), vq[i].level);
         chk({vq[i].name, " empty"}, int'(rif.rempty), int'(vq[i].empty));
         chk({vq[i].name, " ae"},    int'(rif.ralmost_empty), int'(vq[i].ae));
         chk({vq[i].name, " uflow"}, int'(rif.runderflow), int'(vq[i].uf));
         chk({vq[i].name, " raddr"}, int'(rif.raddr), vq[i].raddr);
         chk({vq[i].name, " gray"},  int'(rif.rptr_gray), int'(vq[i].gray));
      end

      // Wrap-around: 16 single-word write/read pairs.
      reset_dut();
      for (int k = 1; k <= 16; k++) begin
         step(1'b0, k);
         check_model("wrap_w");
         step(1'b1, k);
         check_model("wrap_r");
         if (k == 8)  chk("wrap raddr8", int'(rif.raddr), 0);
         if (k == 15) chk("wrap gray15", int'(rif.rptr_gray), 8);
         if (k == 16) begin
            chk("wrap gray16", int'(rif.rptr_gray), 0);
            chk("wrap raddr16", int'(rif.raddr), 0);
         end
      end

      // Completely full as seen from the read side.
      reset_dut();
      step(1'b0, 8);
      check_model("full");
      chk("full level8", int'(rif.rlevel), 8);

      // Asynchronous reset between edges while holding four words.
      reset_dut();
      step(1'b0, 4);
      check_model("pre_arst");
      #2 rrst_n = 1'b0;
      #1 chk_reset_vals("arst");
      @(negedge rclk);
      rrst_n = 1'b1;
      rd_cnt = 0; m_level = 0; m_uf = 1'b0;
      step(1'b0, 4);
      check_model("post_arst");
      step(1'b1, 4);
      check_model("post_arst_rd");

      // Randomised traffic against the counting model.
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         bit ri;
         int w;
         bit fill_phase;
         fill_phase = ((i / 50) % 2) == 0;
         w = wr_cnt;
         if ((wr_cnt - rd_cnt) < 8 && ($urandom_range(0, 2) != 0) == fill_phase) w++;
         ri = (($urandom_range(0, 2) == 0) == fill_phase);
         step(ri, w);
         check_model("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
